// File: rtl/regfile_write_ctrl_pkg.sv
// Shared register-file write types and constants for the write controller
// and for the hazard logic that consumes its forwarding outputs.
package regfile_write_ctrl_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned REG_DW = 32;
    localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic [REG_AW-1:0] dest;
        logic [REG_DW-1:0] val;
        logic              valid;
    } wr_req_t;

endpackage

// File: rtl/wb_pend_fifo.sv
// Circular buffer of pending multi-cycle results. Each entry has a live bit
// that a newer WB write to the same register clears in place.
module wb_pend_fifo
    import regfile_write_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  wr_req_t                  push_req,
    input  logic                     pop,
    input  logic                     kill_en,
    input  logic [REG_AW-1:0]        kill_dest,
    input  logic [REG_AW-1:0]        src1,
    input  logic [REG_AW-1:0]        src2,
    output wr_req_t                  head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     hit1,
    output logic [REG_DW-1:0]        val1,
    output logic                     hit2,
    output logic [REG_DW-1:0]        val2
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [REG_AW-1:0] mem_dest [DEPTH];
    logic [REG_DW-1:0] mem_val  [DEPTH];
    logic [DEPTH-1:0]  live;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     idx;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    assign head.dest  = mem_dest[rd_ptr];
    assign head.val   = mem_val[rd_ptr];
    assign head.valid = live[rd_ptr] && !empty;

    // Live bits are cleared on pop, so a set bit always marks an occupied entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live   <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (kill_en && mem_dest[i] == kill_dest) begin
                    live[i] <= 1'b0;
                end
            end
            if (pop) begin
                live[rd_ptr] <= 1'b0;
                rd_ptr       <= rd_ptr + PW'(1);
            end
            if (push) begin
                live[wr_ptr] <= push_req.valid;
                wr_ptr       <= wr_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_dest[wr_ptr] <= push_req.dest;
            mem_val[wr_ptr]  <= push_req.val;
        end
    end

    // Walk oldest to youngest so the youngest live match wins.
    always_comb begin
        hit1 = 1'b0;
        val1 = '0;
        hit2 = 1'b0;
        val2 = '0;
        idx  = rd_ptr;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if (live[idx] && mem_dest[idx] == src1) begin
                hit1 = 1'b1;
                val1 = mem_val[idx];
            end
            if (live[idx] && mem_dest[idx] == src2) begin
                hit2 = 1'b1;
                val2 = mem_val[idx];
            end
        end
    end

endmodule

// File: rtl/regfile_write_ctrl.sv
// Single write port owner for the register file: merges never-stalled WB
// writes with buffered multi-cycle results and forwards in-flight values.
module regfile_write_ctrl
    import regfile_write_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = REG_DW,
    parameter int unsigned AW    = REG_AW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wb_en,
    input  logic [AW-1:0]          wb_dest,
    input  logic [DW-1:0]          wb_val,
    input  logic                   mc_valid,
    output logic                   mc_ready,
    input  logic [AW-1:0]          mc_dest,
    input  logic [DW-1:0]          mc_val,
    input  logic [AW-1:0]          src1,
    input  logic [AW-1:0]          src2,
    output logic                   fwd1_hit,
    output logic [DW-1:0]          fwd1_val,
    output logic                   fwd2_hit,
    output logic [DW-1:0]          fwd2_val,
    output logic                   Write_EN,
    output logic [AW-1:0]          dest,
    output logic [DW-1:0]          Write_Val,
    output logic [$clog2(DEPTH):0] pending_cnt
);

    wr_req_t           out_q;
    wr_req_t           push_req;
    wr_req_t           head;
    logic              wb_write;
    logic              push;
    logic              pop;
    logic              head_live;
    logic              full;
    logic              empty;
    logic              buf_hit1;
    logic              buf_hit2;
    logic [REG_DW-1:0] buf_val1;
    logic [REG_DW-1:0] buf_val2;

    assign wb_write = wb_en && (wb_dest != AW'(ZERO_REG));
    assign mc_ready = rst && !full;
    assign push     = mc_valid && mc_ready && (mc_dest != AW'(ZERO_REG));

    // A same-cycle WB write to the same register is newer, so the result lands dead.
    assign push_req.dest  = REG_AW'(mc_dest);
    assign push_req.val   = REG_DW'(mc_val);
    assign push_req.valid = !(wb_write && mc_dest == wb_dest);

    assign head_live = head.valid && !(wb_write && head.dest == REG_AW'(wb_dest));
    assign pop       = !empty && (!wb_write || !head_live);

    wb_pend_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_req  (push_req),
        .pop       (pop),
        .kill_en   (wb_write),
        .kill_dest (REG_AW'(wb_dest)),
        .src1      (REG_AW'(src1)),
        .src2      (REG_AW'(src2)),
        .head      (head),
        .count     (pending_cnt),
        .full      (full),
        .empty     (empty),
        .hit1      (buf_hit1),
        .val1      (buf_val1),
        .hit2      (buf_hit2),
        .val2      (buf_val2)
    );

    // WB always wins the port; a live buffer head takes it otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q <= '0;
        end else if (wb_write) begin
            out_q.dest  <= REG_AW'(wb_dest);
            out_q.val   <= REG_DW'(wb_val);
            out_q.valid <= 1'b1;
        end else if (head_live) begin
            out_q <= head;
        end else begin
            out_q.valid <= 1'b0;
        end
    end

    assign Write_EN  = out_q.valid;
    assign dest      = AW'(out_q.dest);
    assign Write_Val = DW'(out_q.val);

    always_comb begin
        fwd1_hit = 1'b0;
        fwd1_val = '0;
        fwd2_hit = 1'b0;
        fwd2_val = '0;
        if (src1 != AW'(ZERO_REG)) begin
            if (buf_hit1) begin
                fwd1_hit = 1'b1;
                fwd1_val = DW'(buf_val1);
            end else if (out_q.valid && out_q.dest == REG_AW'(src1)) begin
                fwd1_hit = 1'b1;
                fwd1_val = DW'(out_q.val);
            end
        end
        if (src2 != AW'(ZERO_REG)) begin
            if (buf_hit2) begin
                fwd2_hit = 1'b1;
                fwd2_val = DW'(buf_val2);
            end else if (out_q.valid && out_q.dest == REG_AW'(src2)) begin
                fwd2_hit = 1'b1;
                fwd2_val = DW'(out_q.val);
            end
        end
    end

endmodule

// File: doc/regfile_write_ctrl.md
Name: regfile_write_ctrl

Overview:
- Owns the single write port of the 32x32 register file; it is the writer for the file's read-only ports.
- Accepts results from two sources:
  - the WB pipeline stage, which is never stalled;
  - a multi-cycle unit (mult/div), which uses a valid/ready handshake.
- Buffers multi-cycle results, orders them against WB writes, and drives one registered write per cycle.
- Supplies forwarding data for reads of registers with in-flight writes.

Parameters:
- DEPTH, 4, number of pending multi-cycle result entries (power of two, at least 2).
- DW, 32, data width.
- AW, 5, register address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- wb_en  in  1  WB stage write request this cycle.
- wb_dest  in  AW  WB destination register.
- wb_val  in  DW  WB write data.
- mc_valid  in  1  multi-cycle result valid.
- mc_ready  out  1  controller can accept a multi-cycle result.
- mc_dest  in  AW  multi-cycle destination register.
- mc_val  in  DW  multi-cycle result data.
- src1  in  AW  forwarding lookup address 1.
- src2  in  AW  forwarding lookup address 2.
- fwd1_hit  out  1  in-flight write exists for src1.
- fwd1_val  out  DW  youngest in-flight value for src1.
- fwd2_hit  out  1  in-flight write exists for src2.
- fwd2_val  out  DW  youngest in-flight value for src2.
- Write_EN  out  1  register-file write enable, active-high, registered.
- dest  out  AW  register-file write address, registered.
- Write_Val  out  DW  register-file write data, registered.
- pending_cnt  out  clog2(DEPTH)+1  number of occupied buffer entries (valid or killed).

Behaviour:
- Reset (rst low, asynchronous):
  - Write_EN=0, dest=0, Write_Val=0.
  - Buffer emptied, pending_cnt=0.
  - mc_ready=0 while rst is low.
  - Reset mid-operation discards all pending results; no partial write is issued.
- Handshake:
  - mc_ready = !full, combinational from the occupancy count; rst low forces it to 0.
  - Transfer occurs on a cycle with mc_valid && mc_ready.
  - mc_dest=0 transfers complete but are not stored.
- Issue, registered, one cycle of latency:
  - If wb_en && wb_dest!=0, the next cycle drives Write_EN=1, dest=wb_dest, Write_Val=wb_val.
  - Otherwise, if the buffer head is valid (not killed), pop it and drive it next cycle.
  - Otherwise Write_EN=0; dest and Write_Val hold their last values.
  - Killed head entries are popped without issuing; at most one pop per cycle.
  - wb_en with wb_dest=0 is ignored and does not block a buffer pop.
- Ordering / kill rules:
  - A WB write to register R kills every buffered entry with dest R in the same cycle.
  - A multi-cycle result for R accepted in the same cycle as a WB write to R is enqueued killed: WB is newer.
  - Buffered valid entries to the same register are retained; they drain in order, so the youngest lands last.
- Boundaries:
  - Full: mc_ready=0.
  - Full and pop in the same cycle: no push that cycle; mc_ready rises the following cycle.
  - Empty and push in the same cycle: the entry is not issued until the next cycle (no cut-through).
  - Sustained WB traffic starves the buffer. Accepted, because the pipeline guarantees WB bubbles.
- Forwarding (combinational, per lookup port):
  - Hit if src != 0 and it matches a valid buffered entry or the output register (Write_EN=1 && dest==src).
  - Priority: youngest matching valid buffer entry, then the output register.
  - No hit gives fwd_val=0.

Decomposition:
- Shared package:
  - REG_AW=5, REG_DW=32, ZERO_REG=5'd0.
  - Write-request struct {dest, val, valid}, reused by the register file write side and hazard logic.
- One sub-module: wb_pend_fifo.
  - Circular buffer with per-entry valid(kill) bit.
  - Parallel dest compare for kill.
  - Youngest-match search for the two forwarding ports.
- Top level holds the issue mux and output registers.

Test Plan:
1. Reset low mid-drain with 3 entries buffered -> Write_EN=0, pending_cnt=0, mc_ready=0 immediately; after release mc_ready=1 and nothing is written.
2. wb_en=1, wb_dest=7, wb_val=0xDEADBEEF -> next cycle Write_EN=1, dest=7, Write_Val=0xDEADBEEF; the following idle cycle Write_EN=0.
3. Push 4 results (dest 3,4,5,6) while WB writes every cycle -> mc_ready=0 after the 4th push; once WB idles, writes 3,4,5,6 issue on consecutive cycles in order.
4. Buffer holds dest 9 = 0x11; WB writes dest 9 = 0x22 -> one write of 0x22 to reg 9; entry is dropped; reg 9 is never written with 0x11.
5. Same-cycle mc (dest 12, 0xAA) and WB (dest 12, 0xBB) -> only 0xBB written; the killed entry occupies and drains with no write.
6. Buffer holds dest 5 = 0x1 then 0x2; src1=5 -> fwd1_hit=1, fwd1_val=0x2. src2=0 -> fwd2_hit=0. mc_dest=0 -> handshake completes, pending_cnt unchanged.
